// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Out-of-range BCD digits saturate to 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the down-counter: load, decrement with 0 -> 9 wrap and borrow.
module bcd_digit_down
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] din,
  input  logic       dec,
  output logic [3:0] dout,
  output logic       borrow_out,
  output logic       is_zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= BCD_ZERO;
    end else if (load) begin
      dout <= din;
    end else if (dec) begin
      dout <= (dout == BCD_ZERO) ? BCD_MAX : dout - 4'd1;
    end
  end

  assign is_zero    = (dout == BCD_ZERO);
  assign borrow_out = dec & is_zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with IDLE/RUN/HOLD control and done/load_err pulses.
// Optional auto-reload on terminal count: define BCD_TIMER_AUTORELOAD_EN.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  input  logic                tick,
  output logic [4*DIGITS-1:0] q,
  output logic                busy,
  output logic                done,
  output logic                load_err,
  output logic [1:0]          dbg_state
);

  state_t state, state_nx;
  logic done_nx, err_nx;

  logic [DIGITS-1:0]   dig_dec, dig_borrow, dig_zero;
  logic [4*DIGITS-1:0] clamped, dig_din;
  logic                dig_load, dec_en, at_zero, upper_zero, will_zero, do_reload, any_bad;
  logic                borrow_unused;

  always_comb begin
    clamped = '0;
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      clamped[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
      if (load_val[4*i +: 4] > BCD_MAX) any_bad = 1'b1;
    end
  end

  // Decrement only in RUN when no higher-priority control is present.
  assign dec_en  = (state == RUN) && tick && !load && !pause;
  assign at_zero = &dig_zero;

  always_comb begin
    upper_zero = 1'b1;
    for (int i = 1; i < DIGITS; i++) upper_zero = upper_zero & dig_zero[i];
  end

  // The decrement about to happen lands on zero exactly when q == 1.
  assign will_zero = dec_en && (q[3:0] == 4'd1) && upper_zero;

`ifdef BCD_TIMER_AUTORELOAD_EN
  logic [4*DIGITS-1:0] reload_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reload_q <= '0;
    else if (load) reload_q <= clamped;
  end

  assign do_reload = will_zero && (|reload_q);
  assign dig_din   = load ? clamped : reload_q;
`else
  assign do_reload = 1'b0;
  assign dig_din   = clamped;
`endif

  assign dig_load = load | do_reload;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign dig_dec[i] = dec_en;
    end else begin : g_upper
      assign dig_dec[i] = dec_en & dig_borrow[i-1];
    end

    bcd_digit_down u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (dig_load),
      .din        (dig_din[4*i +: 4]),
      .dec        (dig_dec[i]),
      .dout       (q[4*i +: 4]),
      .borrow_out (dig_borrow[i]),
      .is_zero    (dig_zero[i])
    );
  end

  // Borrow out of the top digit can never fire: RUN leaves at zero.
  assign borrow_unused = dig_borrow[DIGITS-1];

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    if (load) begin
      state_nx = IDLE;
      err_nx   = any_bad;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (at_zero) done_nx  = 1'b1;
            else         state_nx = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_nx = HOLD;
          end else if (will_zero) begin
            done_nx = 1'b1;
            if (!do_reload) state_nx = IDLE;
          end
        end
        HOLD: begin
          if (start) state_nx = RUN;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      load_err <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      done     <= done_nx;
      load_err <= err_nx;
      busy     <= (state_nx != IDLE);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer against a decimal-integer reference model.
module tb_bcd_countdown_timer;
  import bcd_timer_pkg::*;

  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;
`ifdef BCD_TIMER_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, load, start, pause, tick;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         busy, done, load_err;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: count kept as a plain integer, mode 0 idle / 1 run / 2 hold.
  int   m_val, m_reload, m_mode;
  logic m_done, m_err;

  bcd_countdown_timer #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_val  (load_val),
    .start     (start),
    .pause     (pause),
    .tick      (tick),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .load_err  (load_err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_val = 0; m_reload = 0; m_mode = 0; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic l, input logic [W-1:0] lv, input logic s,
                            input logic p, input logic t);
    int d, v, sc;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (l) begin
      v = 0; sc = 1;
      for (int i = 0; i < DIGITS; i++) begin
        d = int'(lv[4*i +: 4]);
        if (d > 9) begin d = 9; m_err = 1'b1; end
        v  = v + d * sc;
        sc = sc * 10;
      end
      m_val = v; m_reload = v; m_mode = 0;
    end else if (m_mode == 1) begin
      if (p) m_mode = 2;
      else if (t) begin
        m_val = m_val - 1;
        if (m_val == 0) begin
          m_done = 1'b1;
          if (AUTORELOAD && m_reload != 0) m_val = m_reload;
          else m_mode = 0;
        end
      end
    end else if (m_mode == 2) begin
      if (s) m_mode = 1;
    end else begin
      if (s) begin
        if (m_val == 0) m_done = 1'b1;
        else m_mode = 1;
      end
    end
  endtask

  // One clock: drive on the falling edge, advance the model on the rising edge, compare 1 ns later.
  task automatic step(input logic l, input logic [W-1:0] lv, input logic s,
                      input logic p, input logic t);
    @(negedge clk);
    load = l; load_val = lv; start = s; pause = p; tick = t;
    @(posedge clk);
    model_step(l, lv, s, p, t);
    #1;
    check("q", q, to_bcd(m_val));
    check("busy", W'(busy), W'(m_mode != 0));
    check("done", W'(done), W'(m_done));
    check("load_err", W'(load_err), W'(m_err));
  endtask

  initial begin
    int n, dcount;
    logic [W-1:0] lv;
    logic [3:0] dg;

    rst_n = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    model_reset();
    #12;
    check("rst_q", q, '0);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_err", W'(load_err), '0);
    check("rst_state", W'(dbg_state), W'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic countdown from 12 with a tick every cycle.
    step(1'b1, W'(12'h012), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int v = 11; v >= 0; v--) exp_q.push_back(to_bcd(v));
    n = 0;
    while (n < 40 && !done) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n++;
      if (exp_q.size() > 0) check("seq", q, exp_q.pop_front());
    end
    check("tick_count", W'(n), W'(12));
    check("busy_at_done", W'(busy), '0);

    // Borrow ripple through two digits.
    step(1'b1, W'(12'h100), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("ripple_q", q, W'(12'h099));
    check("ripple_done", W'(done), '0);

    // Pause and resume.
    step(1'b1, W'(12'h005), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("hold_q", q, W'(12'h003));
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("resume_q", q, W'(12'h003));
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("resume_done", W'(done), W'(1));

    // Invalid digit clamp, then start on a zero count.
    step(1'b1, W'(12'h0A3), 1'b0, 1'b0, 1'b0);
    check("clamp_q", q, W'(12'h093));
    check("clamp_err", W'(load_err), W'(1));
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("zstart_done", W'(done), W'(1));
    check("zstart_busy", W'(busy), '0);

    // Load wins over the final tick.
    step(1'b1, W'(12'h001), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, W'(12'h004), 1'b0, 1'b0, 1'b1);
    check("load_wins_done", W'(done), '0);

    // Asynchronous reset at q = 07, between clock edges.
    step(1'b1, W'(12'h009), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("pre_reset_q", q, W'(12'h007));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_q", q, '0);
    check("async_busy", W'(busy), '0);
    check("async_done", W'(done), '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Terminal count with continuous ticks (reloads when the feature is built in).
    step(1'b1, W'(12'h003), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    dcount = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      if (done) dcount++;
    end
    check("reload_dones", W'(dcount), AUTORELOAD ? W'(3) : W'(1));

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      lv = '0;
      for (int i = 0; i < DIGITS; i++) begin
        if ($urandom_range(0, 7) == 0) dg = 4'($urandom_range(10, 15));
        else if (i == 0) dg = 4'($urandom_range(0, 9));
        else if (i == 1) dg = 4'($urandom_range(0, 1));
        else dg = 4'd0;
        lv[4*i +: 4] = dg;
      end
      step(($urandom_range(0, 24) == 0), lv, ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 14) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Multi-digit BCD down-counter: the countdown counterpart of the team's decade up-counter. Loads a BCD preset, decrements by one per qualified `tick` with digit-to-digit borrow (0 → 9), and reports terminal count with a one-cycle `done` pulse. It is used wherever a decimal timeout or display countdown is required.

## Interface
- `DIGITS`, default 2: number of BCD digits. Minimum 1. Digit 0 is the least significant.
- `clk` input 1: clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `load` input 1: capture `load_val` into the count.
- `load_val` input 4*DIGITS: BCD preset. Digit i is `[4i+3:4i]`.
- `start` input 1: begin or resume counting.
- `pause` input 1: freeze counting.
- `tick` input 1: count qualifier. One decrement per sampled-high cycle in RUN.
- `q` output 4*DIGITS: current BCD count, registered.
- `busy` output 1: high while in RUN or HOLD, registered.
- `done` output 1: one-cycle pulse on reaching zero, or on `start` with a zero count.
- `load_err` output 1: one-cycle pulse when any `load_val` digit is greater than 9.

## Operation
- States: IDLE, RUN, HOLD.
- Priority each cycle: `load` > `pause` > `start` > `tick`.
- `load` in any state:
  - Each digit greater than 9 is clamped to 9 and raises `load_err`.
  - The state goes to IDLE.
  - `tick`, `start` and `pause` are ignored in that cycle.
- IDLE:
  - `start` with q ≠ 0 → RUN.
  - `start` with q = 0 → pulse `done` and stay in IDLE.
  - `tick` and `pause` are ignored.
- RUN:
  - `pause` → HOLD with no decrement, even if `tick` is high.
  - `tick` decrements q by 1 in BCD. Digit 0 rolls 0 → 9 and borrows from the next digit; borrow ripples.
  - When the decrement makes q = 0: pulse `done` and go to IDLE.
  - `start` is ignored.
- HOLD:
  - `start` → RUN. No decrement in the resume cycle.
  - `tick` and `pause` are ignored. q is held.
- The count never goes below 0, because RUN exits at zero.
- Arithmetic is per-digit 4-bit only. There is no binary intermediate.

## Timing
- Reset values: q = 0, `busy` = 0, `done` = 0, `load_err` = 0, state = IDLE, reload register = 0.
- Reset is honoured mid-count. It takes effect immediately, with no pending `done`.
- Latency:
  - q reflects a `tick` or `load` on the next rising edge after it is sampled.
  - `done` and `load_err` are high for the single cycle following the edge that wrote zero, or that sampled the `start`/`load` condition.
  - `busy` rises on the cycle after `start` is accepted.
  - `busy` falls in the same cycle that `done` is high.
- A count of N takes exactly N qualified ticks to reach zero.
- A `load` in the same cycle as the final `tick` wins: no `done` is pulsed.

## Configuration
- Macro: `BCD_TIMER_AUTORELOAD_EN`.
- When defined:
  - A reload register captures the clamped preset on every `load`.
  - On reaching zero in RUN, `done` pulses, q is reloaded from the register in the same edge, and the state stays RUN with `busy` held high.
  - If the reload value is 0, behaviour is as without the macro.
- When undefined: no reload register. On reaching zero the state goes to IDLE and q holds 0.

## Structure
- Shared package `bcd_timer_pkg` contains:
  - the state enum (IDLE, RUN, HOLD);
  - the `BCD_MAX` = 4'd9 and `BCD_ZERO` = 4'd0 constants;
  - a per-digit clamp function.
- Sub-module `bcd_digit_down`:
  - Ports: `clk`, `rst_n`, `load`, `din`, `dec`; outputs `dout`, `borrow_out`, `is_zero`.
  - Instantiated DIGITS times via generate.
  - Each digit's `dec` is the previous digit's `borrow_out`, ANDed with the decrement enable.
- The top level holds the FSM, the zero detect (AND of `is_zero`), and the pulse registers.

## Test plan
- Basic countdown:
  - Stimulus: reset, load 8'h12, start, `tick` every cycle.
  - Response: q goes 12, 11, 10, 09, …, 01, 00. `done` is high for one cycle after 00 is written. `busy` drops in that cycle. Exactly 12 ticks are consumed.
- Borrow ripple:
  - Stimulus: DIGITS=3, load 12'h100, start, one tick.
  - Response: q = 12'h099, no `done`.
- Pause and resume:
  - Stimulus: load 8'h05, start, two ticks; then assert `pause` and `tick` together; hold 3 cycles with `tick` high; then start; then ticks.
  - Response: q = 03 held throughout HOLD. The resume cycle does not decrement. `done` follows 3 more ticks.
- Invalid load and zero start:
  - Stimulus 1: load 8'hA3.
  - Response 1: q = 8'h93, `load_err` pulses once.
  - Stimulus 2: load 8'h00, then start.
  - Response 2: `done` pulses, `busy` stays 0.
- Async reset mid-count and auto-reload:
  - Stimulus 1: drive `rst_n` low between clock edges at q = 07.
  - Response 1: q = 0, `busy` = 0, `done` = 0, all immediately.
  - Stimulus 2: with `BCD_TIMER_AUTORELOAD_EN` defined, load 8'h03, start, continuous ticks.
  - Response 2: q goes 03, 02, 01, 03, 02, … with `done` every 3 ticks and `busy` never falling.
